// File: rtl/mem_controller.sv
// Byte-serial memory controller: round-robin arbitration between ICache fetches and
// LSB loads/stores onto a single 8-bit RAM/IO port, one byte per cycle.
module mem_controller #(
  parameter logic [31:0] IO_BASE = 32'h30000
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        icFlagIn,
  input  logic [31:0] icAddrIn,
  output logic        icValidOut,
  output logic [31:0] icDataOut,
  input  logic        lsFlagIn,
  input  logic        lsWriteIn,
  input  logic [31:0] lsAddrIn,
  input  logic [1:0]  lsWidthIn,
  input  logic [31:0] lsDataIn,
  output logic        lsValidOut,
  output logic [31:0] lsDataOut,
  input  logic [7:0]  memDataIn,
  output logic [7:0]  memDataOut,
  output logic [31:0] memAddrOut,
  output logic        memWrOut,
  input  logic        ioBufferFullIn
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] acc_q;
  logic [31:0] last_addr_q;
  logic [2:0]  k_q;
  logic [2:0]  n_q;
  logic        wr_q;
  logic        src_ls_q;
  logic        last_ic_q;

  logic [31:0] addr_d;
  logic [2:0]  ls_n;
  logic [1:0]  cap_idx;
  logic        stall;
  logic        abort;
  logic        grant_ic;
  logic        grant_ls;
  logic        done_ok;

  // Address for this cycle; READ stops issuing once all N addresses are out.
  always_comb begin
    addr_d = 32'h0;
    if ((state_q == READ && k_q != n_q) || state_q == WRITE)
      addr_d = addr_q + {29'h0, k_q};
  end

  always_comb begin
    case (lsWidthIn)
      2'd0:    ls_n = 3'd1;
      2'd1:    ls_n = 3'd2;
      default: ls_n = 3'd4;
    endcase
  end

  assign cap_idx  = k_q[1:0] - 2'd1;
  assign stall    = (state_q == WRITE) && (addr_d >= IO_BASE) && ioBufferFullIn;
  assign abort    = clearIn && !wr_q && (state_q == READ || state_q == DONE);
  assign grant_ic = icFlagIn && (!lsFlagIn || !last_ic_q);
  assign grant_ls = lsFlagIn && !grant_ic;
  assign done_ok  = readyIn && (state_q == DONE) && !abort;

  // During a pause the previous cycle's address is re-presented so the byte
  // returned after resume still belongs to the address awaiting capture.
  assign memAddrOut = readyIn ? addr_d : last_addr_q;
  assign memWrOut   = readyIn && (state_q == WRITE) && !stall;
  assign memDataOut = (state_q == WRITE) ? wdata_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
  assign icValidOut = done_ok && !src_ls_q;
  assign lsValidOut = done_ok && src_ls_q;
  assign icDataOut  = icValidOut ? acc_q : 32'h0;
  assign lsDataOut  = lsValidOut ? acc_q : 32'h0;

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state_q     <= IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      acc_q       <= 32'h0;
      last_addr_q <= 32'h0;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      wr_q        <= 1'b0;
      src_ls_q    <= 1'b0;
      last_ic_q   <= 1'b0;
    end else if (readyIn) begin
      last_addr_q <= addr_d;
      case (state_q)
        IDLE: begin
          if (grant_ic || grant_ls) begin
            last_ic_q <= grant_ic;
            src_ls_q  <= grant_ls;
            k_q       <= 3'd0;
            acc_q     <= 32'h0;
            if (grant_ic) begin
              addr_q  <= icAddrIn;
              wr_q    <= 1'b0;
              n_q     <= 3'd4;
              wdata_q <= 32'h0;
              state_q <= READ;
            end else begin
              addr_q  <= lsAddrIn;
              wr_q    <= lsWriteIn;
              n_q     <= ls_n;
              wdata_q <= lsDataIn;
              state_q <= lsWriteIn ? WRITE : READ;
            end
          end
        end
        READ: begin
          if (clearIn) begin
            state_q <= IDLE;
          end else begin
            if (k_q != 3'd0)
              acc_q[{cap_idx, 3'b000} +: 8] <= memDataIn;
            if (k_q == n_q)
              state_q <= DONE;
            else
              k_q <= k_q + 3'd1;
          end
        end
        WRITE: begin
          if (!stall) begin
            if (k_q == n_q - 3'd1)
              state_q <= DONE;
            else
              k_q <= k_q + 3'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: byte RAM model, per-transaction expectations
// queued at stimulus time and matched against valid pulses and memory writes.
module tb_mem_controller;

  localparam logic [31:0] IO_BASE = 32'h30000;

  logic        clockIn = 1'b0;
  logic        resetIn, readyIn, clearIn;
  logic        icFlagIn, icValidOut;
  logic [31:0] icAddrIn, icDataOut;
  logic        lsFlagIn, lsWriteIn, lsValidOut;
  logic [31:0] lsAddrIn, lsDataIn, lsDataOut;
  logic [1:0]  lsWidthIn;
  logic [7:0]  memDataIn, memDataOut;
  logic [31:0] memAddrOut;
  logic        memWrOut, ioBufferFullIn;

  mem_controller #(.IO_BASE(IO_BASE)) dut (
    .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .clearIn(clearIn),
    .icFlagIn(icFlagIn), .icAddrIn(icAddrIn), .icValidOut(icValidOut), .icDataOut(icDataOut),
    .lsFlagIn(lsFlagIn), .lsWriteIn(lsWriteIn), .lsAddrIn(lsAddrIn), .lsWidthIn(lsWidthIn),
    .lsDataIn(lsDataIn), .lsValidOut(lsValidOut), .lsDataOut(lsDataOut),
    .memDataIn(memDataIn), .memDataOut(memDataOut), .memAddrOut(memAddrOut),
    .memWrOut(memWrOut), .ioBufferFullIn(ioBufferFullIn)
  );

  always #5 clockIn = ~clockIn;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t exp_ic[$];
  exp_t exp_ls[$];
  exp_t exp_wr[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t;
  logic [7:0] mem [0:18'h3FFFF];

  // Synchronous byte RAM: data for the address of cycle c appears in cycle c+1.
  always @(posedge clockIn) begin
    logic [7:0] rd;
    cyc <= cyc + 1;
    rd = (memAddrOut < IO_BASE) ? mem[memAddrOut[17:0]] : 8'h00;
    if (memWrOut && memAddrOut < IO_BASE)
      mem[memAddrOut[17:0]] = memDataOut;
    memDataIn <= rd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic push_ic(input int c, input logic [31:0] d);
    exp_ic.push_back('{c, 32'h0, d, 1'b1});
  endtask

  task automatic push_ls(input int c, input logic [31:0] d, input bit chk);
    exp_ls.push_back('{c, 32'h0, d, chk});
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    exp_wr.push_back('{c, a, {24'h0, d}, 1'b1});
  endtask

  // Scoreboard: every write and valid pulse must match the head of its queue.
  always @(negedge clockIn) begin
    exp_t e;
    if (memWrOut) begin
      if (exp_wr.size() == 0) check_eq("wr_spurious", {31'h0, memWrOut}, 32'h0);
      else begin
        e = exp_wr.pop_front();
        check_eq("wr_cycle", cyc, e.cyc);
        check_eq("wr_addr", memAddrOut, e.addr);
        check_eq("wr_data", {24'h0, memDataOut}, e.data);
        $display("write  cycle %0d addr %h data %h", cyc, memAddrOut, memDataOut);
      end
    end
    if (icValidOut) begin
      if (exp_ic.size() == 0) check_eq("ic_spurious", {31'h0, icValidOut}, 32'h0);
      else begin
        e = exp_ic.pop_front();
        check_eq("ic_cycle", cyc, e.cyc);
        check_eq("ic_data", icDataOut, e.data);
        $display("fetch  cycle %0d data %h", cyc, icDataOut);
      end
    end
    if (lsValidOut) begin
      if (exp_ls.size() == 0) check_eq("ls_spurious", {31'h0, lsValidOut}, 32'h0);
      else begin
        e = exp_ls.pop_front();
        check_eq("ls_cycle", cyc, e.cyc);
        if (e.chk) check_eq("ls_data", lsDataOut, e.data);
        $display("lsb    cycle %0d data %h", cyc, lsDataOut);
      end
    end
  end

  task automatic ic_req(input logic [31:0] a);
    bit seen = 1'b0;
    icAddrIn = a;
    icFlagIn = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clockIn);
      seen = icValidOut;
    end
    check_eq("ic_done_in_time", {31'h0, seen}, 32'h1);
    step();
    icFlagIn = 1'b0;
  endtask

  task automatic ls_req(input logic wr, input logic [1:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    bit seen = 1'b0;
    lsWriteIn = wr;
    lsWidthIn = w;
    lsAddrIn  = a;
    lsDataIn  = d;
    lsFlagIn  = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clockIn);
      seen = lsValidOut;
    end
    check_eq("ls_done_in_time", {31'h0, seen}, 32'h1);
    step();
    lsFlagIn = 1'b0;
  endtask

  task automatic do_reset();
    resetIn = 1'b1;
    step();
    step();
    resetIn = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    resetIn = 1'b1; readyIn = 1'b1; clearIn = 1'b0; ioBufferFullIn = 1'b0;
    icFlagIn = 1'b0; icAddrIn = 32'h0;
    lsFlagIn = 1'b0; lsWriteIn = 1'b0; lsAddrIn = 32'h0; lsWidthIn = 2'd0; lsDataIn = 32'h0;
    for (int i = 0; i < 32'h40000; i++) mem[i] = 8'h00;
    mem[18'h100] = 8'h13;
    mem[18'h000] = 8'h11; mem[18'h001] = 8'h22; mem[18'h002] = 8'h33; mem[18'h003] = 8'h44;
    mem[18'h004] = 8'h55; mem[18'h005] = 8'h66; mem[18'h006] = 8'h77; mem[18'h007] = 8'h88;
    mem[18'h2000] = 8'h5A; mem[18'h2001] = 8'hA5;
    mem[18'h042] = 8'h77;
    mem[18'h500] = 8'hEF; mem[18'h501] = 8'hBE; mem[18'h502] = 8'hAD;
    mem[18'h400] = 8'h04; mem[18'h401] = 8'h03; mem[18'h402] = 8'h02; mem[18'h403] = 8'h01;

    // Reset state
    repeat (3) step();
    @(negedge clockIn);
    check_eq("rst_addr", memAddrOut, 32'h0);
    check_eq("rst_wr", {31'h0, memWrOut}, 32'h0);
    check_eq("rst_wdata", {24'h0, memDataOut}, 32'h0);
    check_eq("rst_ic_valid", {31'h0, icValidOut}, 32'h0);
    check_eq("rst_ls_valid", {31'h0, lsValidOut}, 32'h0);
    step();
    resetIn = 1'b0;
    step();

    // Word fetch: addresses in t+1..t+4, valid at t+6
    t = cyc;
    push_ic(t + 6, 32'h00000013);
    fork
      ic_req(32'h100);
      begin
        @(negedge clockIn);
        for (int i = 1; i <= 4; i++) begin
          @(negedge clockIn);
          check_eq("fetch_addr", memAddrOut, 32'h100 + i - 1);
          check_eq("fetch_wr", {31'h0, memWrOut}, 32'h0);
        end
      end
    join
    step();

    // Round-robin tie from reset, then a repeated tie
    do_reset();
    t = cyc;
    push_ic(t + 6, 32'h44332211);
    push_ls(t + 10, 32'h0000005A, 1'b1);
    fork
      ic_req(32'h0);
      ls_req(1'b0, 2'd0, 32'h2000, 32'h0);
    join
    step();
    t = cyc;
    push_ic(t + 6, 32'h88776655);
    push_ls(t + 10, 32'h000000A5, 1'b1);
    fork
      ic_req(32'h4);
      ls_req(1'b0, 2'd0, 32'h2001, 32'h0);
    join
    step();

    // Half store
    t = cyc;
    push_wr(t + 1, 32'h40, 8'hDD);
    push_wr(t + 2, 32'h41, 8'hCC);
    push_ls(t + 3, 32'h0, 1'b0);
    ls_req(1'b1, 2'd1, 32'h40, 32'hAABBCCDD);
    check_eq("half_mem40", {24'h0, mem[18'h040]}, 32'hDD);
    check_eq("half_mem41", {24'h0, mem[18'h041]}, 32'hCC);
    check_eq("half_mem42", {24'h0, mem[18'h042]}, 32'h77);
    step();

    // Half load is zero-extended
    t = cyc;
    push_ls(t + 4, 32'h0000BEEF, 1'b1);
    ls_req(1'b0, 2'd1, 32'h500, 32'h0);
    step();

    // I/O stall for three cycles
    t = cyc;
    push_wr(t + 4, IO_BASE, 8'h41);
    push_ls(t + 5, 32'h0, 1'b0);
    fork
      ls_req(1'b1, 2'd0, IO_BASE, 32'h41);
      begin
        step();
        ioBufferFullIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clockIn);
          check_eq("stall_wr", {31'h0, memWrOut}, 32'h0);
          check_eq("stall_addr", memAddrOut, IO_BASE);
          step();
        end
        ioBufferFullIn = 1'b0;
      end
    join
    step();

    // Flush during a word load: back to IDLE, no valid
    lsWriteIn = 1'b0; lsWidthIn = 2'd2; lsAddrIn = 32'h200; lsFlagIn = 1'b1;
    step();
    step();
    clearIn = 1'b1;
    lsFlagIn = 1'b0;
    step();
    clearIn = 1'b0;
    @(negedge clockIn);
    check_eq("flush_idle_addr", memAddrOut, 32'h0);
    repeat (8) step();

    // Flush during a word store: all bytes still written
    t = cyc;
    push_wr(t + 1, 32'h300, 8'hEF);
    push_wr(t + 2, 32'h301, 8'hBE);
    push_wr(t + 3, 32'h302, 8'hAD);
    push_wr(t + 4, 32'h303, 8'hDE);
    push_ls(t + 5, 32'h0, 1'b0);
    fork
      ls_req(1'b1, 2'd2, 32'h300, 32'hDEADBEEF);
      begin
        step();
        step();
        clearIn = 1'b1;
        step();
        clearIn = 1'b0;
      end
    join
    step();

    // Two-cycle pause mid word fetch
    t = cyc;
    push_ic(t + 8, 32'h01020304);
    fork
      ic_req(32'h400);
      begin
        step();
        step();
        @(negedge clockIn);
        check_eq("pause_pre_addr", memAddrOut, 32'h401);
        step();
        readyIn = 1'b0;
        for (int i = 0; i < 2; i++) begin
          @(negedge clockIn);
          check_eq("pause_addr_held", memAddrOut, 32'h401);
          check_eq("pause_wr", {31'h0, memWrOut}, 32'h0);
          step();
        end
        readyIn = 1'b1;
        @(negedge clockIn);
        check_eq("pause_resume_addr", memAddrOut, 32'h402);
      end
    join
    repeat (4) step();

    check_eq("ic_queue_empty", exp_ic.size(), 32'h0);
    check_eq("ls_queue_empty", exp_ls.size(), 32'h0);
    check_eq("wr_queue_empty", exp_wr.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
